s_store_unit: RTL and testbench
===============================

Name: s_store_unit

Overview:
Execute/memory-stage block that consumes the S-type fields from the S-type instruction decoder: imm_MSB, imm_LSB, funct3, plus the register-file values for rs1 and rs2. It computes the effective address, lane-aligns store data, generates byte enables and drives a single-outstanding write request to data memory with a req/ack handshake. Misaligned, illegal and timed-out stores are reported as one-cycle pulses.

Parameters:
XLEN, 32, datapath and address width (only 32 supported)
MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ack before bus error (1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  decoded S-type store presented
s_ready  output  1  unit can accept a store (high only in IDLE)
imm_MSB  input  7  instruction bits [31:25]
imm_LSB  input  5  instruction bits [11:7]
funct3  input  3  store width: 000 SB, 001 SH, 010 SW
rs1_data  input  32  base address register value
rs2_data  input  32  store data register value
mem_req  output  1  write request to data memory
mem_addr  output  32  byte address, word-aligned ({addr[31:2],2'b00})
mem_wdata  output  32  lane-replicated write data
mem_be  output  4  byte enables
mem_ack  input  1  memory accepted write
done  output  1  one-cycle pulse: store completed
misaligned  output  1  one-cycle pulse: address misaligned for width
illegal  output  1  one-cycle pulse: funct3 not 000/001/010
bus_err  output  1  one-cycle pulse: ack timeout
exc_addr  output  32  full effective address of last faulting store

Behaviour:
- Reset (async, rst_n low): state=IDLE; mem_req, done, misaligned, illegal, bus_err=0; mem_addr, mem_wdata, exc_addr=0; mem_be=0000; timeout counter=0. Reset mid-request drops mem_req immediately and discards the store.
- imm = sign-extend({imm_MSB,imm_LSB}) to 32 bits; ea = rs1_data + imm, mod 2^32, no overflow flag.
- SB: be = 4'b0001 << ea[1:0]; wdata = {4{rs2[7:0]}}; never misaligned.
- SH: misaligned if ea[0]=1; be = ea[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
- SW: misaligned if ea[1:0]!=00; be = 1111; wdata = rs2.
- Illegal takes priority over misaligned.
- FSM states: IDLE, ISSUE, DONE, FAULT, ERR. s_ready = (state==IDLE).
- IDLE: on s_valid&s_ready at edge N, register mem_addr/mem_wdata/mem_be.
  - Fault-free: go to ISSUE.
  - Otherwise: go to FAULT, register exc_addr=ea, mem_be stays 0000.
- ISSUE: mem_req=1; addr/wdata/be held stable; counter increments each cycle.
  - mem_ack sampled high -> DONE.
  - Counter reaching MEM_TIMEOUT with no ack -> ERR, exc_addr=ea.
  - Ack in the same cycle as timeout: ack wins (DONE).
- DONE: done=1 for one cycle, mem_req=0, counter cleared -> IDLE.
- FAULT: misaligned or illegal =1 for one cycle, no mem_req -> IDLE.
- ERR: bus_err=1 for one cycle, mem_req=0, counter cleared -> IDLE.
- Latency with immediate ack: accept at edge N, mem_req high in cycle N+1, done in N+2, s_ready high in N+3. Throughput: one store per 3 cycles minimum.
- mem_ack outside ISSUE is ignored. Inputs are not sampled outside the accept edge. s_valid held during non-IDLE states has no effect.
- mem_addr, mem_wdata, mem_be hold their last values after completion. exc_addr holds until the next fault.

Test Plan:
- SB: imm_MSB=0000111, imm_LSB=11101 (imm=0x0FD), rs1=0x00001000, rs2=0x000000AB, funct3=000, ack next cycle -> mem_addr=0x000010FC, be=0010, wdata=0xABABABAB, done at N+2.
- SW, same imm/rs1 with funct3=010 -> no mem_req; misaligned pulse one cycle; exc_addr=0x000010FD; s_ready high 2 cycles after accept.
- Negative imm: imm_MSB=1000100, imm_LSB=00001 (imm=0xFFFFF881), rs1=0x0000207F, rs2=0xDEADBEEF, SW -> mem_addr=0x00001900, be=1111, wdata=0xDEADBEEF, done.
- SH: imm=0, rs1=0x00000006, rs2=0x1234CAFE -> be=1100, wdata=0xCAFECAFE. With rs1=0x00000005 -> misaligned pulse. funct3=011 -> illegal pulse, not misaligned.
- Timeout: legal SW, mem_ack never asserted -> mem_req high exactly 15 cycles, then bus_err pulse and return to IDLE. Repeat with ack on the 15th cycle -> done, no bus_err.
- Reset mid-ISSUE: drop rst_n while mem_req=1 -> mem_req=0 asynchronously, all outputs zero. After release, a new SB completes normally.

Source files
------------

// File: rtl/s_store_unit.sv
// rtl/s_store_unit.sv - S-type store unit: address calc, lane alignment, single-outstanding memory write
module s_store_unit #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [6:0]      imm_MSB,
    input  logic [4:0]      imm_LSB,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    output logic            done,
    output logic            misaligned,
    output logic            illegal,
    output logic            bus_err,
    output logic [XLEN-1:0] exc_addr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DONE  = 3'd2,
        FAULT = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t          state, state_n;
    logic [7:0]      cnt;
    logic [XLEN-1:0] ea_q;
    logic            fault_ill_q;

    logic [11:0]     imm12;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] ea;
    logic [3:0]      be_n;
    logic [XLEN-1:0] wdata_n;
    logic            mis_n;
    logic            ill_n;
    logic            accept;
    logic            timeout;

    assign imm12   = {imm_MSB, imm_LSB};
    assign imm     = {{(XLEN-12){imm12[11]}}, imm12};
    assign ea      = rs1_data + imm;
    assign accept  = s_valid && (state == IDLE);
    assign timeout = (cnt == CNT_LAST);

    // Width decode: lane enables, replicated data and fault classification
    always_comb begin
        be_n    = 4'b0000;
        wdata_n = rs2_data;
        mis_n   = 1'b0;
        ill_n   = 1'b0;
        case (funct3)
            3'b000: begin
                be_n    = 4'b0001 << ea[1:0];
                wdata_n = {4{rs2_data[7:0]}};
            end
            3'b001: begin
                be_n    = ea[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{rs2_data[15:0]}};
                mis_n   = ea[0];
            end
            3'b010: begin
                be_n    = 4'b1111;
                mis_n   = (ea[1:0] != 2'b00);
            end
            default: begin
                ill_n   = 1'b1;
            end
        endcase
    end

    // Next-state logic; ack wins over a simultaneous timeout
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) state_n = (ill_n || mis_n) ? FAULT : ISSUE;
            end
            ISSUE: begin
                if (mem_ack)      state_n = DONE;
                else if (timeout) state_n = ERR;
            end
            DONE:    state_n = IDLE;
            FAULT:   state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Request capture, ack-wait counter and fault address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= 4'b0000;
            exc_addr    <= '0;
            ea_q        <= '0;
            fault_ill_q <= 1'b0;
            cnt         <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (accept) begin
                        ea_q        <= ea;
                        fault_ill_q <= ill_n;
                        if (ill_n || mis_n) begin
                            mem_be   <= 4'b0000;
                            exc_addr <= ea;
                        end else begin
                            mem_addr  <= {ea[XLEN-1:2], 2'b00};
                            mem_wdata <= wdata_n;
                            mem_be    <= be_n;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 8'd1;
                    if (!mem_ack && timeout) exc_addr <= ea_q;
                end
                default: cnt <= 8'd0;
            endcase
        end
    end

    assign s_ready    = (state == IDLE);
    assign mem_req    = (state == ISSUE);
    assign done       = (state == DONE);
    assign misaligned = (state == FAULT) && !fault_ill_q;
    assign illegal    = (state == FAULT) && fault_ill_q;
    assign bus_err    = (state == ERR);

endmodule

// File: tb/tb_s_store_unit.sv
// tb/tb_s_store_unit.sv - directed self-checking bench for s_store_unit
module tb_s_store_unit;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [6:0]  imm_MSB;
    logic [4:0]  imm_LSB;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        misaligned;
    logic        illegal;
    logic        bus_err;
    logic [31:0] exc_addr;

    int checks   = 0;
    int failures = 0;

    s_store_unit #(.XLEN(32), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .imm_MSB(imm_MSB), .imm_LSB(imm_LSB), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .done(done),
        .misaligned(misaligned), .illegal(illegal), .bus_err(bus_err),
        .exc_addr(exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a store for one accept edge; returns just after edge N
    task automatic issue(input logic [6:0] msb, input logic [4:0] lsb, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        @(negedge clk);
        check("s_ready_before_accept", 32'(s_ready), 32'd1);
        imm_MSB  = msb;
        imm_LSB  = lsb;
        funct3   = f3;
        rs1_data = rs1;
        rs2_data = rs2;
        s_valid  = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    // Ack in cycle N+1, expect done in N+2 and ready in N+3
    task automatic ack_next(input string tag);
        @(negedge clk);
        check({tag, "_req"}, 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_req_low"}, 32'(mem_req), 32'd0);
        @(negedge clk);
        check({tag, "_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_done_low"}, 32'(done), 32'd0);
    endtask

    // Fault path: pulse in N+1, ready in N+2
    task automatic fault_expect(input string tag, input logic mis, input logic ill, input logic [31:0] ea);
        @(negedge clk);
        check({tag, "_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mis"}, 32'(misaligned), 32'(mis));
        check({tag, "_ill"}, 32'(illegal), 32'(ill));
        check({tag, "_exc"}, exc_addr, ea);
        check({tag, "_be"}, 32'(mem_be), 32'd0);
        @(negedge clk);
        check({tag, "_mis_low"}, 32'(misaligned | illegal), 32'd0);
        check({tag, "_ready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        int req_cycles;
        int saw_err;
        rst_n = 1'b0; s_valid = 1'b0; mem_ack = 1'b0;
        imm_MSB = '0; imm_LSB = '0; funct3 = '0; rs1_data = '0; rs2_data = '0;
        #12;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_exc", exc_addr, 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // SB at ea 0x10FD
        issue(7'b0000111, 5'b11101, 3'b000, 32'h0000_1000, 32'h0000_00AB);
        @(negedge clk);
        check("sb_addr", mem_addr, 32'h0000_10FC);
        check("sb_be", 32'(mem_be), 32'b0010);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_ready_busy", 32'(s_ready), 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("sb_done", 32'(done), 32'd1);
        @(negedge clk);
        check("sb_ready", 32'(s_ready), 32'd1);

        // SW misaligned at 0x10FD
        issue(7'b0000111, 5'b11101, 3'b010, 32'h0000_1000, 32'h0000_00AB);
        fault_expect("sw_mis", 1'b1, 1'b0, 32'h0000_10FD);

        // SW with negative immediate
        issue(7'b1000100, 5'b00001, 3'b010, 32'h0000_207F, 32'hDEAD_BEEF);
        @(negedge clk);
        check("neg_addr", mem_addr, 32'h0000_1900);
        check("neg_be", 32'(mem_be), 32'b1111);
        check("neg_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("neg_done", 32'(done), 32'd1);

        // SH upper half
        issue(7'd0, 5'd0, 3'b001, 32'h0000_0006, 32'h1234_CAFE);
        @(negedge clk);
        check("sh_addr", mem_addr, 32'h0000_0004);
        check("sh_be", 32'(mem_be), 32'b1100);
        check("sh_wdata", mem_wdata, 32'hCAFE_CAFE);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("sh_done", 32'(done), 32'd1);

        // SH misaligned, then illegal funct3 with same odd address
        issue(7'd0, 5'd0, 3'b001, 32'h0000_0005, 32'h1234_CAFE);
        fault_expect("sh_mis", 1'b1, 1'b0, 32'h0000_0005);
        issue(7'd0, 5'd0, 3'b011, 32'h0000_0005, 32'h1234_CAFE);
        fault_expect("ill", 1'b0, 1'b1, 32'h0000_0005);

        // Timeout: no ack ever
        issue(7'd0, 5'd8, 3'b010, 32'h0000_0100, 32'h5555_AAAA);
        req_cycles = 0;
        saw_err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            if (bus_err) begin
                saw_err = 1;
                break;
            end
        end
        check("to_req_cycles", 32'(req_cycles), 32'd15);
        check("to_bus_err", 32'(saw_err), 32'd1);
        check("to_exc", exc_addr, 32'h0000_0108);
        @(negedge clk);
        check("to_ready", 32'(s_ready), 32'd1);
        check("to_err_low", 32'(bus_err), 32'd0);

        // Ack on the 15th request cycle wins over timeout
        issue(7'd0, 5'd4, 3'b010, 32'h0000_0200, 32'h0F0F_0F0F);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 15) begin
                check("late_req15", 32'(mem_req), 32'd1);
                mem_ack = 1'b1;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_done", 32'(done), 32'd1);
        check("late_no_err", 32'(bus_err), 32'd0);
        check("late_exc_kept", exc_addr, 32'h0000_0108);
        @(negedge clk);
        check("late_ready", 32'(s_ready), 32'd1);

        // Reset while request outstanding
        issue(7'd0, 5'd0, 3'b010, 32'h0000_0300, 32'h1111_2222);
        @(negedge clk);
        check("rmid_req_pre", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_req", 32'(mem_req), 32'd0);
        check("rmid_addr", mem_addr, 32'd0);
        check("rmid_wdata", mem_wdata, 32'd0);
        check("rmid_exc", exc_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(7'd0, 5'd3, 3'b000, 32'h0000_0400, 32'h0000_0077);
        @(negedge clk);
        check("post_addr", mem_addr, 32'h0000_0400);
        check("post_be", 32'(mem_be), 32'b1000);
        check("post_wdata", mem_wdata, 32'h7777_7777);
        ack_next("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
